// File: rtl/pe_ws_db.sv
// pe_ws_db -- weight-stationary processing element with double-buffered weights.
//
// Purpose:
//   One tile of a systolic array. Activations stream left-to-right and
//   weights/partial sums flow top-to-bottom. The next tile's weight is
//   loaded into a shadow register while the current tile computes. w_swap
//   then promotes it to the active register, so no load bubbles are needed.
//   A vertical drain chain (drain/shift) moves finished sums out of the column.
//
// Optional feature:
//   PE_WS_DB_SAT_EN -- when defined, accumulation saturates on signed overflow
//   and sat_flag becomes a sticky overflow indicator. When undefined, acc
//   wraps as two's complement and sat_flag is tied to 0.
//
// Parameters:
//   DATA_W  signed activation/weight width
//   ACC_W   signed accumulator width (must be >= 2*DATA_W+1)
//   PIPE    1 = registered activation forwarding, 0 = combinational
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   a_in, a_valid_in            activation and qualifier from the left
//   w_in, w_load, w_swap        weight data, shadow load, shadow->active swap
//   en, clr                     MAC enable, start a new accumulation
//   drain, shift, psum_in       drain-chain controls and partial sum from above
//   a_out, a_valid_out          forwarded activation and qualifier
//   w_out, w_load_out,
//   w_swap_out                  weight chain to the PE below (always registered)
//   acc                         accumulator
//   psum_out                    drain-chain register
//   sat_flag                    sticky overflow flag (0 without saturation)
module pe_ws_db #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int PIPE   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] a_in,
  input  logic              a_valid_in,
  input  logic [DATA_W-1:0] w_in,
  input  logic              w_load,
  input  logic              w_swap,
  input  logic              en,
  input  logic              clr,
  input  logic              drain,
  input  logic              shift,
  input  logic [ACC_W-1:0]  psum_in,
  output logic [DATA_W-1:0] a_out,
  output logic              a_valid_out,
  output logic [DATA_W-1:0] w_out,
  output logic              w_load_out,
  output logic              w_swap_out,
  output logic [ACC_W-1:0]  acc,
  output logic [ACC_W-1:0]  psum_out,
  output logic              sat_flag
);

  // The full product must fit with one guard bit to spare.
  generate
    if (ACC_W < 2*DATA_W + 1) begin : g_bad_acc_w
      $error("pe_ws_db: ACC_W must be >= 2*DATA_W+1");
    end
  endgenerate

  localparam int PROD_W = 2*DATA_W;

  logic [DATA_W-1:0]        shadow_w_reg;
  logic [DATA_W-1:0]        active_w_reg;
  logic [ACC_W-1:0]         acc_reg;
  logic [ACC_W-1:0]         acc_next;
  logic [ACC_W-1:0]         psum_reg;
  logic [DATA_W-1:0]        w_out_reg;
  logic                     w_load_out_reg;
  logic                     w_swap_out_reg;

  logic signed [PROD_W-1:0] product;
  logic [ACC_W-1:0]         product_ext;
  logic [ACC_W-1:0]         base;
  logic [ACC_W-1:0]         sum;
  logic                     fire;

  assign fire        = en & a_valid_in;
  // The multiply always sees the active weight held at this edge, so a
  // simultaneous w_swap only takes effect for the next MAC.
  assign product     = $signed(a_in) * $signed(active_w_reg);
  assign product_ext = {{(ACC_W-PROD_W){product[PROD_W-1]}}, product};
  // clr with fire restarts from zero instead of the running total.
  assign base        = clr ? '0 : acc_reg;
  assign sum         = base + product_ext;

`ifdef PE_WS_DB_SAT_EN
  logic ovf;
  logic sat_reg;

  // Signed overflow: operands share a sign and the result sign differs.
  assign ovf = fire & (base[ACC_W-1] == product_ext[ACC_W-1])
                    & (sum[ACC_W-1] != base[ACC_W-1]);

  always_comb begin
    acc_next = acc_reg;
    if (fire) begin
      if (ovf) begin
        acc_next = base[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                 : {1'b0, {(ACC_W-1){1'b1}}};
      end else begin
        acc_next = sum;
      end
    end else if (clr) begin
      acc_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_reg <= 1'b0;
    end else begin
      sat_reg <= (clr ? 1'b0 : sat_reg) | ovf;
    end
  end

  assign sat_flag = sat_reg;
`else
  always_comb begin
    acc_next = acc_reg;
    if (fire) begin
      acc_next = sum;
    end else if (clr) begin
      acc_next = '0;
    end
  end

  assign sat_flag = 1'b0;
`endif

  // Weights, accumulator, drain chain and weight-chain forwarding.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_w_reg   <= '0;
      active_w_reg   <= '0;
      acc_reg        <= '0;
      psum_reg       <= '0;
      w_out_reg      <= '0;
      w_load_out_reg <= 1'b0;
      w_swap_out_reg <= 1'b0;
    end else begin
      // Nonblocking semantics give swap the old shadow when both are set.
      if (w_load) shadow_w_reg <= w_in;
      if (w_swap) active_w_reg <= shadow_w_reg;
      acc_reg <= acc_next;
      // drain captures the pre-update acc, allowing overlap with clr/fire.
      if (drain) begin
        psum_reg <= acc_reg;
      end else if (shift) begin
        psum_reg <= psum_in;
      end
      w_out_reg      <= w_in;
      w_load_out_reg <= w_load;
      w_swap_out_reg <= w_swap;
    end
  end

  // Activation forwarding: registered or pass-through.
  generate
    if (PIPE != 0) begin : g_pipe
      logic [DATA_W-1:0] a_out_reg;
      logic              a_valid_out_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_out_reg       <= '0;
          a_valid_out_reg <= 1'b0;
        end else begin
          a_out_reg       <= a_in;
          a_valid_out_reg <= a_valid_in;
        end
      end

      assign a_out       = a_out_reg;
      assign a_valid_out = a_valid_out_reg;
    end else begin : g_comb
      assign a_out       = a_in;
      assign a_valid_out = a_valid_in;
    end
  endgenerate

  assign acc        = acc_reg;
  assign psum_out   = psum_reg;
  assign w_out      = w_out_reg;
  assign w_load_out = w_load_out_reg;
  assign w_swap_out = w_swap_out_reg;

endmodule

// File: tb/tb_pe_ws_db.sv
// tb_pe_ws_db -- self-checking bench for pe_ws_db (DATA_W=8, ACC_W=16).
// u0 uses registered forwarding (PIPE=1); u1 is the combinational variant
// (PIPE=0) driven by the same inputs. The bench follows PE_WS_DB_SAT_EN for
// its saturation expectations.
module tb_pe_ws_db;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  a_in;
  logic        a_valid_in;
  logic [7:0]  w_in;
  logic        w_load, w_swap, en, clr, drain, shift;
  logic [15:0] psum_in;

  logic signed [7:0]  a_out0, a_out1, w_out0, w_out1;
  logic               a_valid_out0, a_valid_out1;
  logic               w_load_out0, w_load_out1, w_swap_out0, w_swap_out1;
  logic signed [15:0] acc0, acc1, psum0, psum1;
  logic               sat0, sat1;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state (plain integers)
  int m_shadow, m_active, m_acc, m_psum;
  bit m_sat;

  always #5 clk = ~clk;

  pe_ws_db #(.DATA_W(8), .ACC_W(16), .PIPE(1)) u0 (
    .clk(clk), .rst(rst), .a_in(a_in), .a_valid_in(a_valid_in),
    .w_in(w_in), .w_load(w_load), .w_swap(w_swap), .en(en), .clr(clr),
    .drain(drain), .shift(shift), .psum_in(psum_in),
    .a_out(a_out0), .a_valid_out(a_valid_out0), .w_out(w_out0),
    .w_load_out(w_load_out0), .w_swap_out(w_swap_out0),
    .acc(acc0), .psum_out(psum0), .sat_flag(sat0)
  );

  pe_ws_db #(.DATA_W(8), .ACC_W(16), .PIPE(0)) u1 (
    .clk(clk), .rst(rst), .a_in(a_in), .a_valid_in(a_valid_in),
    .w_in(w_in), .w_load(w_load), .w_swap(w_swap), .en(en), .clr(clr),
    .drain(drain), .shift(shift), .psum_in(psum_in),
    .a_out(a_out1), .a_valid_out(a_valid_out1), .w_out(w_out1),
    .w_load_out(w_load_out1), .w_swap_out(w_swap_out1),
    .acc(acc1), .psum_out(psum1), .sat_flag(sat1)
  );

  task automatic check(input string name, input longint got, input longint exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  function automatic int wrap16(input int v);
    return ((v + 32768) & 32'hFFFF) - 32768;
  endfunction

  // Next-state model computed from the current inputs.
  task automatic model_update();
    int  prod, total;
    bit  fire;
    if (rst) begin
      m_shadow = 0; m_active = 0; m_acc = 0; m_psum = 0; m_sat = 0;
    end else begin
      fire = en && a_valid_in;
      prod = int'($signed(a_in)) * m_active;
      if (drain)      m_psum = m_acc;
      else if (shift) m_psum = int'($signed(psum_in));
      if (clr) m_sat = 0;
      if (fire) begin
        total = (clr ? 0 : m_acc) + prod;
        if (total > 32767 || total < -32768) begin
`ifdef PE_WS_DB_SAT_EN
          m_sat = 1;
          total = (total > 0) ? 32767 : -32768;
`else
          total = wrap16(total);
`endif
        end
        m_acc = total;
      end else if (clr) begin
        m_acc = 0;
      end
      if (w_swap) m_active = m_shadow;
      if (w_load) m_shadow = int'($signed(w_in));
    end
  endtask

  task automatic cycle();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    rst = 0; a_in = 0; a_valid_in = 0; w_in = 0; w_load = 0; w_swap = 0;
    en = 0; clr = 0; drain = 0; shift = 0; psum_in = 0;
  endtask

  typedef struct {
    bit wl; bit ws; int w; bit en; bit av; int a;
    bit clr; bit dr; bit sh; int pin; int e_acc; int e_psum;
  } vec_t;

  vec_t tbl[19];
  int   exp_sat_acc;
  bit   exp_sat_flag;

  initial begin
    m_shadow = 0; m_active = 0; m_acc = 0; m_psum = 0; m_sat = 0;

    // ---------------- Reset with all inputs nonzero ----------------
    rst = 1; a_in = 8'h55; a_valid_in = 1; w_in = 8'h33; w_load = 1;
    w_swap = 1; en = 1; clr = 1; drain = 1; shift = 1; psum_in = 16'h1234;
    cycle();
    check("rst_acc",        acc0, 0);
    check("rst_psum",       psum0, 0);
    check("rst_sat",        sat0, 0);
    check("rst_a_out",      a_out0, 0);
    check("rst_a_valid",    a_valid_out0, 0);
    check("rst_w_out",      w_out0, 0);
    check("rst_w_load_out", w_load_out0, 0);
    check("rst_w_swap_out", w_swap_out0, 0);
    check("rst_acc_p0",     acc1, 0);
    check("rst_psum_p0",    psum1, 0);
    cycle();
    check("rst2_acc",       acc0, 0);
    set_idle();

    // ---------------- Directed table ----------------
    //            wl ws  w   en av   a  clr dr sh pin  acc  psum
    tbl[0]  = '{1, 0,  3,  0, 0,   0, 0, 0, 0,  0,   0,   0};
    tbl[1]  = '{0, 1,  0,  0, 0,   0, 0, 0, 0,  0,   0,   0};
    tbl[2]  = '{0, 0,  0,  1, 1,   2, 0, 0, 0,  0,   6,   0};
    tbl[3]  = '{1, 0, -4,  1, 1,  -5, 0, 0, 0,  0,  -9,   0};
    tbl[4]  = '{0, 0,  0,  1, 1,   7, 0, 0, 0,  0,  12,   0};
    tbl[5]  = '{0, 1,  0,  0, 0,   0, 0, 0, 0,  0,  12,   0};
    tbl[6]  = '{0, 0,  0,  1, 1,   1, 1, 0, 0,  0,  -4,   0};
    tbl[7]  = '{1, 0,  5,  0, 0,   0, 1, 0, 0,  0,   0,   0};
    tbl[8]  = '{1, 1,  9,  0, 0,   0, 0, 0, 0,  0,   0,   0};
    tbl[9]  = '{0, 1,  0,  1, 1,   1, 0, 0, 0,  0,   5,   0};
    tbl[10] = '{0, 0,  0,  1, 1,   1, 1, 0, 0,  0,   9,   0};
    tbl[11] = '{1, 0, 10,  0, 0,   0, 0, 0, 0,  0,   9,   0};
    tbl[12] = '{0, 1,  0,  0, 0,   0, 0, 0, 0,  0,   9,   0};
    tbl[13] = '{0, 0,  0,  1, 1,  10, 1, 0, 0,  0, 100,   0};
    tbl[14] = '{1, 0,  2,  0, 0,   0, 0, 0, 0,  0, 100,   0};
    tbl[15] = '{0, 1,  0,  0, 0,   0, 0, 0, 0,  0, 100,   0};
    tbl[16] = '{0, 0,  0,  1, 1,   3, 1, 1, 0,  0,   6, 100};
    tbl[17] = '{0, 0,  0,  0, 0,   0, 0, 0, 1, 77,   6,  77};
    tbl[18] = '{0, 0,  0,  1, 0,   5, 0, 0, 0,  0,   6,  77};

    for (int i = 0; i < 19; i++) begin
      w_load = tbl[i].wl; w_swap = tbl[i].ws; w_in = 8'(tbl[i].w);
      en = tbl[i].en; a_valid_in = tbl[i].av; a_in = 8'(tbl[i].a);
      clr = tbl[i].clr; drain = tbl[i].dr; shift = tbl[i].sh;
      psum_in = 16'(tbl[i].pin);
      cycle();
      $display("vec %0d: acc=%0d psum=%0d a_out=%0d a_valid_out=%0d", i, acc0, psum0, a_out0, a_valid_out0);
      check($sformatf("vec%0d_acc", i),     acc0, tbl[i].e_acc);
      check($sformatf("vec%0d_acc_p0", i),  acc1, tbl[i].e_acc);
      check($sformatf("vec%0d_psum", i),    psum0, tbl[i].e_psum);
      check($sformatf("vec%0d_sat", i),     sat0, 0);
      check($sformatf("vec%0d_a_out", i),   a_out0, tbl[i].a);
      check($sformatf("vec%0d_a_valid", i), a_valid_out0, tbl[i].av);
      check($sformatf("vec%0d_w_out", i),   w_out0, tbl[i].w);
      check($sformatf("vec%0d_w_load_out", i), w_load_out0, tbl[i].wl);
      check($sformatf("vec%0d_w_swap_out", i), w_swap_out0, tbl[i].ws);
      check($sformatf("vec%0d_a_out_p0", i),   a_out1, tbl[i].a);
    end

    // ---------------- PIPE=0 combinational vs PIPE=1 registered ----------------
    a_in = 8'(-37); a_valid_in = 1; en = 0;
    #1;
    $display("comb: a_out_p0=%0d a_out_p1=%0d", a_out1, a_out0);
    check("comb_a_out_p0",   a_out1, -37);
    check("comb_a_valid_p0", a_valid_out1, 1);
    check("comb_a_out_p1",   a_out0, 5);
    check("comb_a_valid_p1", a_valid_out0, 0);
    set_idle();
    cycle();

    // ---------------- Saturation: w=-128, a=-128 ----------------
    clr = 1; w_load = 1; w_in = 8'h80;
    cycle();
    set_idle(); w_swap = 1;
    cycle();
    set_idle(); en = 1; a_valid_in = 1; a_in = 8'h80; clr = 1;
    cycle();
    $display("sat step1: acc=%0d sat=%0d", acc0, sat0);
    check("sat_first_acc", acc0, 16384);
    clr = 0;
    cycle();
`ifdef PE_WS_DB_SAT_EN
    exp_sat_acc = 32767; exp_sat_flag = 1;
`else
    exp_sat_acc = -32768; exp_sat_flag = 0;
`endif
    $display("sat step2: acc=%0d sat=%0d", acc0, sat0);
    check("sat_second_acc",  acc0, exp_sat_acc);
    check("sat_second_flag", sat0, exp_sat_flag);
    cycle();
`ifdef PE_WS_DB_SAT_EN
    exp_sat_acc = 32767;
`else
    exp_sat_acc = -16384;
`endif
    $display("sat step3: acc=%0d sat=%0d", acc0, sat0);
    check("sat_third_acc",  acc0, exp_sat_acc);
    check("sat_third_flag", sat0, exp_sat_flag);
    set_idle();
    cycle();
    check("sat_hold_flag", sat0, exp_sat_flag);
    clr = 1;
    cycle();
    $display("sat clr: acc=%0d sat=%0d", acc0, sat0);
    check("sat_clr_flag", sat0, 0);
    check("sat_clr_acc",  acc0, 0);
    set_idle();

    // ---------------- Randomized against the model ----------------
    for (int i = 0; i < 400; i++) begin
      rst        = ($urandom_range(0, 49) == 0);
      a_in       = 8'($urandom);
      a_valid_in = ($urandom_range(0, 3) != 0);
      w_in       = 8'($urandom);
      w_load     = ($urandom_range(0, 3) == 0);
      w_swap     = ($urandom_range(0, 5) == 0);
      en         = ($urandom_range(0, 4) != 0);
      clr        = ($urandom_range(0, 7) == 0);
      drain      = ($urandom_range(0, 5) == 0);
      shift      = ($urandom_range(0, 3) == 0);
      psum_in    = 16'($urandom);
      cycle();
      $display("rand %0d: acc=%0d exp=%0d psum=%0d exp=%0d sat=%0d exp=%0d",
               i, acc0, m_acc, psum0, m_psum, sat0, m_sat);
      check($sformatf("rand%0d_acc", i),    acc0, m_acc);
      check($sformatf("rand%0d_psum", i),   psum0, m_psum);
      check($sformatf("rand%0d_sat", i),    sat0, m_sat);
      check($sformatf("rand%0d_acc_p0", i), acc1, m_acc);
      check($sformatf("rand%0d_a_out", i),  a_out0, rst ? 0 : int'($signed(a_in)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pe_ws_db.md
# pe_ws_db

Parametrised weight-stationary processing element with a double-buffered weight register, valid-qualified activation streaming, a vertical partial-sum drain chain and optional saturating accumulation. It is the array tile of the next systolic array generation: rows stream activations left-to-right, columns load weights and drain results top-to-bottom. The next tile's weights load into the shadow register while the current tile computes, so there are no idle load cycles.

## Interface
- DATA_W, 8: signed activation and weight width.
- ACC_W, 32: signed accumulator width. Must be >= 2*DATA_W+1; elaboration fails otherwise.
- PIPE, 1: 1 = activation forwarding is registered; 0 = combinational pass-through.

- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- a_in  in  DATA_W  signed activation from the left neighbour.
- a_valid_in  in  1  a_in qualifier.
- w_in  in  DATA_W  signed weight data from above.
- w_load  in  1  write w_in into the shadow weight register.
- w_swap  in  1  copy the shadow weight into the active weight register.
- en  in  1  MAC enable.
- clr  in  1  start a new accumulation.
- drain  in  1  capture acc into psum_out.
- shift  in  1  load psum_in into psum_out (drain chain).
- psum_in  in  ACC_W  partial sum from the PE above.
- a_out  out  DATA_W  forwarded activation.
- a_valid_out  out  1  forwarded qualifier.
- w_out  out  DATA_W  w_in registered 1 cycle (column weight chain).
- w_load_out, w_swap_out  out  1 each  w_load and w_swap registered 1 cycle.
- acc  out  ACC_W  accumulator.
- psum_out  out  ACC_W  drain-chain register.
- sat_flag  out  1  sticky overflow indicator.

## Operation
- Weights:
  - w_load=1: shadow_w <= w_in.
  - w_swap=1: active_w <= shadow_w.
  - Both asserted in the same cycle: active_w takes the old shadow value and shadow_w takes w_in.
- MAC:
  - Product is a_in*active_w, full 2*DATA_W signed width, sign-extended to ACC_W.
  - A MAC fires only when en && a_valid_in.
  - A MAC always uses the active_w value present in that cycle, even if w_swap is asserted in the same cycle.
- Accumulator update, in priority order:
  - clr && fire: acc <= product.
  - clr alone: acc <= 0.
  - fire: acc <= acc + product.
  - Otherwise acc holds.
- Drain:
  - drain=1: psum_out <= acc, using the value before this cycle's update.
  - else shift=1: psum_out <= psum_in.
  - Otherwise psum_out holds.
  - drain together with clr and/or fire is legal. This is how back-to-back tiles run without bubbles.
- w_load and en in the same cycle is legal; shadow loading never disturbs acc.
- sat_flag is cleared by rst or clr. It is set per the Configuration section.

## Timing
- Reset: every register and output is 0, including shadow_w, active_w, acc, psum_out, sat_flag, a_out, a_valid_out, w_out, w_load_out and w_swap_out.
- rst asserted mid-accumulation clears everything at the next edge. rst has priority over all other inputs.
- MAC latency: 1 cycle from the fire edge to acc.
- Swap latency: 1 cycle. A fire in the cycle after w_swap uses the new weight.
- Forwarding latency:
  - PIPE=1: a_out and a_valid_out lag 1 cycle.
  - PIPE=0: a_out and a_valid_out are combinational.
  - w_out, w_load_out and w_swap_out are always registered.
- Drain chain: a column of N PEs empties in 1 drain cycle followed by N-1 shift cycles.

## Configuration
- PE_WS_DB_SAT_EN defined:
  - On signed overflow of acc + product (including the clr && fire path), acc clamps to 2^(ACC_W-1)-1 or -2^(ACC_W-1).
  - sat_flag is set the same cycle and stays set until clr or rst.
- PE_WS_DB_SAT_EN undefined:
  - acc wraps as two's complement.
  - sat_flag is tied to 0.

## Test plan
- Reset: drive all inputs nonzero with rst=1 for 2 cycles -> every output is 0 on the cycle after the first rst edge.
- Double buffer:
  - Load 3, swap, then fire with a=2,-5,7 -> acc = 6, -9, 12.
  - Load -4 into the shadow register during that stream -> acc is unaffected.
  - Swap, then clr with fire at a=1 -> acc=-4.
- Load and swap in the same cycle: shadow=5, then w_load(w_in=9) with w_swap -> active=5, shadow=9. A second swap followed by fire at a=1 from acc=0 -> acc=9.
- Drain overlap:
  - acc=100; drain+clr+fire with a=3, w=2 -> psum_out=100, acc=6.
  - Next cycle shift with psum_in=77 -> psum_out=77, acc holds 6.
- Saturation with DATA_W=8, ACC_W=16, w=-128, a=-128, two fires from acc=0:
  - With the macro: acc=32767, sat_flag=1.
  - Without the macro: acc=-32768, sat_flag=0.
- Valid gating: en=1, a_valid_in=0, a=5 -> acc unchanged. With PIPE=1, a_out=5 and a_valid_out=0 one cycle later.
